sensor_pipe_filter: RTL and testbench
=====================================

Name: sensor_pipe_filter

Overview:
- Parametrised successor to the fixed 3-stage sensor transfer pipeline.
- Carries multi-channel sensor samples through a configurable-depth elastic pipeline with full valid/ready backpressure.
- Optional per-channel moving-average filter, selected per sample.
- Sits between sensor acquisition front-ends and the transmission/packetiser logic.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- STAGES, 3, pipeline register stages (legal range 2..8).
- CH_BITS, 2, channel-id width; number of channels is 2**CH_BITS.
- AVG_LOG2, 2, log2 of the moving-average window (window 4 at default; legal range 1..4).

Ports:
- clk, input, 1, the single clock.
- reset_n, input, 1, reset.
- in_data, input, DATA_WIDTH, sensor sample.
- in_ch, input, CH_BITS, channel id of the sample.
- in_valid, input, 1, sample offered.
- in_ready, output, 1, pipeline accepts the sample this cycle.
- mode, input, 1, 1 = filtered output, 0 = pass-through; sampled with the sample.
- out_data, output, DATA_WIDTH, processed sample.
- out_ch, output, CH_BITS, channel id travelling with out_data.
- out_valid, output, 1, out_data/out_ch valid.
- out_ready, input, 1, downstream accepts.

Interface: one clock; reset is asynchronous and active-low. reset_n asserts asynchronously and deasserts synchronously to clk (synchroniser is external).

Behaviour:
- Reset values:
  - All stage valid bits 0, so out_valid=0.
  - out_data=0, out_ch=0.
  - All channel histories and sums 0.
  - in_ready=1 once reset_n is high.
- Stage k holds {data, ch, valid}. Stage k advances when its valid is 0 or stage k+1 will advance. The last stage advances when out_valid is 0 or out_ready is 1.
- in_ready = stage-0 advance condition. This is a combinational ready chain, with no skid buffer.
- A transfer occurs on a clock edge where valid and ready are both high, on either side.
- Latency: exactly STAGES cycles from input transfer to out_valid when never stalled. Throughput is 1 sample/cycle.
- Stall rules:
  - While out_valid=1 and out_ready=0, out_data and out_ch hold stable.
  - Bubbles collapse: a stalled pipeline fills every empty stage before in_ready drops.
  - No sample is lost, duplicated or reordered.
- Filter, evaluated in stage 0 on each input transfer:
  - Per-channel history: a ring of 2**AVG_LOG2 samples plus a running sum of width DATA_WIDTH+AVG_LOG2, unsigned.
  - new_sum = sum - oldest + in_data. The new sample replaces the oldest entry and the ring pointer advances modulo the window.
  - History and sum update on every transfer regardless of mode, so a mode switch takes effect on the next sample with no warm-up discontinuity.
  - mode=1: payload = new_sum >> AVG_LOG2, truncated and unsigned.
  - mode=0: payload = in_data.
  - Warm-up: the history starts at zero, so the first window-1 filtered outputs per channel ramp up (e.g. a constant 100 at window 4 yields 25, 50, 75, 100).
- Channels are independent. Interleaving channels never mixes their histories.
- No history update occurs without a transfer; a stalled in_valid does not update.
- Simultaneous input accept and output drain on a full pipeline: both occur and occupancy is unchanged.
- Reset mid-operation:
  - All in-flight samples are discarded and histories cleared immediately.
  - out_valid drops asynchronously.
  - No output is produced for pre-reset samples after reset releases.
- Sum arithmetic never overflows by construction, because its width covers window × max sample.

Optional Feature:
- Macro: SENSOR_PIPE_STATS_EN.
- When defined, adds two ports:
  - stall_count, output, 16: saturating count of cycles with out_valid=1 and out_ready=0.
  - sample_count, output, 16: wrapping count of output transfers.
- Both counters reset to 0 and clear on reset_n low.
- stall_count holds at 16'hFFFF once reached.
- When not defined, neither port nor any counter logic exists. Data-path behaviour is identical in both builds.

Test Plan:
- STAGES=3, mode=0, out_ready=1, in_data=0x1234 ch=1 at cycle 0 → out_data=0x1234, out_ch=1, out_valid=1 at cycle 3, for one cycle only.
- mode=1, ch 0 constant 100 for 5 samples → outputs 25, 50, 75, 100, 100.
- Interleave ch0=40 and ch2=400, each four times, mode=1 → ch0 outputs 10, 20, 30, 40 and ch2 outputs 100, 200, 300, 400, with correct out_ch on each.
- Stream 10 samples (0..9), hold out_ready=0 from cycle 4 to cycle 12:
  - in_ready drops after STAGES samples are held.
  - out_data is stable throughout the stall.
  - After release, outputs are 0..9 in order with no gaps.
- Stream ch 3 samples, assert reset_n=0 mid-stream for 2 cycles:
  - out_valid goes to 0 immediately.
  - After release, the first filtered ch 3 sample of 80 gives 20 (history cleared).
- Build with SENSOR_PIPE_STATS_EN and stall out_ready for 7 cycles around 5 transfers → stall_count=7, sample_count=5. Forced 70000 stall cycles → stall_count=0xFFFF.

Source files
------------

// File: rtl/sensor_pipe_filter.sv
// Elastic multi-channel sensor pipeline with per-channel moving-average filter.
// Define SENSOR_PIPE_STATS_EN to add the stall_count/sample_count ports.
module sensor_pipe_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 3,
  parameter int CH_BITS    = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_BITS-1:0]    in_ch,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_BITS-1:0]    out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SENSOR_PIPE_STATS_EN
  ,
  output logic [15:0]           stall_count,
  output logic [15:0]           sample_count
`endif
);

  localparam int NCH = 1 << CH_BITS;
  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = DATA_WIDTH + AVG_LOG2;

  logic [DATA_WIDTH-1:0] st_data [STAGES];
  logic [CH_BITS-1:0]    st_ch   [STAGES];
  logic [STAGES-1:0]     st_vld;
  logic [STAGES-1:0]     adv;

  logic [DATA_WIDTH-1:0] hist [NCH][WIN];
  logic [SW-1:0]         sum  [NCH];
  logic [AVG_LOG2-1:0]   ptr  [NCH];

  logic                  xfer_in;
  logic [DATA_WIDTH-1:0] oldest;
  logic [SW-1:0]         new_sum;
  logic [DATA_WIDTH-1:0] payload;

  // A stage may move when any stage at or after it is empty, or the sink drains.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!st_vld[j]) adv[k] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];
  assign xfer_in  = in_valid & in_ready;

  always_comb begin
    oldest  = hist[in_ch][ptr[in_ch]];
    new_sum = sum[in_ch] - SW'(oldest) + SW'(in_data);
    payload = mode ? new_sum[SW-1:AVG_LOG2] : in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        sum[c] <= '0;
        ptr[c] <= '0;
        for (int w = 0; w < WIN; w++) hist[c][w] <= '0;
      end
    end else if (xfer_in) begin
      hist[in_ch][ptr[in_ch]] <= in_data;
      sum[in_ch]              <= new_sum;
      ptr[in_ch]              <= ptr[in_ch] + AVG_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_data[k] <= '0;
        st_ch[k]   <= '0;
      end
    end else begin
      if (adv[0]) begin
        st_vld[0] <= in_valid;
        if (in_valid) begin
          st_data[0] <= payload;
          st_ch[0]   <= in_ch;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          st_vld[k] <= st_vld[k-1];
          if (st_vld[k-1]) begin
            st_data[k] <= st_data[k-1];
            st_ch[k]   <= st_ch[k-1];
          end
        end
      end
    end
  end

  assign out_data  = st_data[STAGES-1];
  assign out_ch    = st_ch[STAGES-1];
  assign out_valid = st_vld[STAGES-1];

`ifdef SENSOR_PIPE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count  <= '0;
      sample_count <= '0;
    end else begin
      if (out_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (out_valid && out_ready)
        sample_count <= sample_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_pipe_filter.sv
// Randomised and directed bench for sensor_pipe_filter against a queue model.
// Stats checks are compiled only with SENSOR_PIPE_STATS_EN.
module tb_sensor_pipe_filter;

  localparam int DW  = 16;
  localparam int ST  = 3;
  localparam int CB  = 2;
  localparam int AL  = 2;
  localparam int WIN = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic [CB-1:0] in_ch;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [DW-1:0] out_data;
  logic [CB-1:0] out_ch;
  logic          out_valid;
  logic          out_ready;
`ifdef SENSOR_PIPE_STATS_EN
  logic [15:0]   stall_count;
  logic [15:0]   sample_count;
`endif

  sensor_pipe_filter #(
    .DATA_WIDTH(DW), .STAGES(ST), .CH_BITS(CB), .AVG_LOG2(AL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_ch(in_ch),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef SENSOR_PIPE_STATS_EN
    , .stall_count(stall_count), .sample_count(sample_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW+CB-1:0] exp_q [$];
  int unsigned      ch_hist [4][$];

  logic          ov, ir, drained, have;
  logic [DW-1:0] od;
  logic [CB-1:0] oc;
  logic [DW+CB-1:0] e;

  function automatic void model_clear();
    exp_q.delete();
    for (int c = 0; c < 4; c++) ch_hist[c].delete();
  endfunction

  // Average of the last WIN samples of the channel, missing ones count as 0.
  function automatic void model_push(logic [DW-1:0] d, logic [CB-1:0] c, logic m);
    int unsigned s;
    int n;
    s = 0;
    ch_hist[c].push_back(d);
    n = ch_hist[c].size();
    for (int i = 0; i < WIN && i < n; i++) s += ch_hist[c][n-1-i];
    exp_q.push_back({c, m ? DW'(s / WIN) : d});
  endfunction

  task automatic tick(input logic v, input logic [DW-1:0] d,
                      input logic [CB-1:0] c, input logic m, input logic ordy);
    @(negedge clk);
    in_valid = v; in_data = d; in_ch = c; mode = m; out_ready = ordy;
    #1;
    ov = out_valid; od = out_data; oc = out_ch; ir = in_ready;
    if (v && ir) model_push(d, c, m);
    drained = ov && ordy;
    have = 1'b0;
    e = '0;
    if (drained && exp_q.size() != 0) begin
      have = 1'b1;
      e = exp_q.pop_front();
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = 0; in_ch = 0; mode = 0; out_ready = 1;
    reset_n = 1'b0;
    model_clear();
    #12;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (out_data !== '0) begin
      fails++; $display("FAIL reset_out_data got %h want 0", out_data);
    end
    tests++;
    if (out_ch !== '0) begin
      fails++; $display("FAIL reset_out_ch got %0d want 0", out_ch);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    do_reset();
    tick(1'b1, 16'h1234, 2'd1, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      tests++;
      if (ov !== (cyc == 3)) begin
        fails++; $display("FAIL latency_valid cyc=%0d got %b want %b", cyc, ov, cyc == 3);
      end
      if (cyc == 3) begin
        tests++;
        if (od !== 16'h1234 || oc !== 2'd1) begin
          fails++; $display("FAIL latency_data got %0d:%h want 1:1234", oc, od);
        end
      end
    end
  endtask

  task automatic test_warmup();
    int want [5] = '{25, 50, 75, 100, 100};
    int sent = 0, got = 0;
    do_reset();
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      tick(sent < 5, 16'd100, 2'd0, 1'b1, 1'b1);
      if (sent < 5 && ir) sent++;
      if (drained) begin
        tests++;
        if (od !== DW'(want[got]) || oc !== 2'd0 || !have || {oc, od} !== e) begin
          fails++; $display("FAIL warmup[%0d] got %0d:%0d want 0:%0d", got, oc, od, want[got]);
        end
        got++;
      end
    end
    tests++;
    if (got != 5) begin
      fails++; $display("FAIL warmup_count got %0d want 5", got);
    end
  endtask

  task automatic test_interleave();
    int sent = 0, got = 0;
    logic [CB-1:0] wc;
    int wd;
    do_reset();
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      tick(sent < 8, (sent % 2) ? 16'd400 : 16'd40,
           (sent % 2) ? 2'd2 : 2'd0, 1'b1, 1'b1);
      if (sent < 8 && ir) sent++;
      if (drained) begin
        wc = (got % 2) ? 2'd2 : 2'd0;
        wd = ((got % 2) ? 100 : 10) * (got / 2 + 1);
        tests++;
        if (oc !== wc || od !== DW'(wd) || !have || {oc, od} !== e) begin
          fails++; $display("FAIL interleave[%0d] got %0d:%0d want %0d:%0d", got, oc, od, wc, wd);
        end
        got++;
      end
    end
    tests++;
    if (got != 8) begin
      fails++; $display("FAIL interleave_count got %0d want 8", got);
    end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, bad = 0;
    logic ordy;
    logic [DW-1:0] held;
    logic [CB-1:0] sch;
    do_reset();
    sch = CB'($urandom);
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      ordy = !(cyc >= 4 && cyc <= 12);
      tick(sent < 10, DW'(sent), sch, 1'b0, ordy);
      if (sent < 10 && ir) sent++;
      if (cyc == 4) held = od;
      if (cyc > 4 && cyc <= 12 && (od !== held || ov !== 1'b1)) bad++;
      if (cyc == 12) begin
        tests++;
        if (ir !== 1'b0 || sent - got != ST) begin
          fails++; $display("FAIL stall_fill in_ready=%b held=%0d want 0/%0d", ir, sent - got, ST);
        end
      end
      if (drained) begin
        tests++;
        if (od !== DW'(got) || oc !== sch || !have || {oc, od} !== e) begin
          fails++; $display("FAIL stall_order[%0d] got %0d want %0d", got, od, got);
        end
        got++;
      end
    end
    tests++;
    if (bad != 0 || got != 10) begin
      fails++; $display("FAIL stall_hold unstable=%0d outputs=%0d want 0/10", bad, got);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0, extra = 0;
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick(1'b1, DW'($urandom_range(0, 1000)), 2'd3, 1'b1, 1'b1);
      if (drained) begin
        tests++;
        if (!have || {oc, od} !== e) begin
          fails++; $display("FAIL midrst_pre got %0d:%0d want %0d:%0d", oc, od, e[DW+CB-1:DW], e[DW-1:0]);
        end
      end
    end
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_async got %b want 0", out_valid);
    end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 16'd80, 2'd3, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      if (drained) begin
        if (got == 0) begin
          tests++;
          if (od !== 16'd20 || oc !== 2'd3 || !have || {oc, od} !== e) begin
            fails++; $display("FAIL midrst_first got %0d:%0d want 3:20", oc, od);
          end
        end else extra++;
        got++;
      end
    end
    tests++;
    if (got != 1 || extra != 0) begin
      fails++; $display("FAIL midrst_count got %0d want 1", got);
    end
  endtask

  task automatic test_random();
    logic v, m, ordy, pstall;
    logic [DW-1:0] d, pd;
    logic [CB-1:0] c, pc;
    int bad_hold = 0;
    do_reset();
    pstall = 1'b0; pd = '0; pc = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom % 4) != 0;
      d = DW'($urandom);
      c = CB'($urandom);
      m = 1'($urandom);
      ordy = ($urandom % 3) != 0;
      tick(v, d, c, m, ordy);
      if (pstall && (ov !== 1'b1 || od !== pd || oc !== pc)) bad_hold++;
      pstall = ov && !ordy; pd = od; pc = oc;
      if (drained) begin
        tests++;
        if (!have || {oc, od} !== e) begin
          fails++; $display("FAIL random cyc=%0d got %0d:%h want %0d:%h", cyc, oc, od, e[DW+CB-1:DW], e[DW-1:0]);
        end
      end
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      if (drained) begin
        tests++;
        if (!have || {oc, od} !== e) begin
          fails++; $display("FAIL random_drain got %0d:%h want %0d:%h", oc, od, e[DW+CB-1:DW], e[DW-1:0]);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0 || bad_hold != 0) begin
      fails++; $display("FAIL random_end pending=%0d unstable=%0d want 0/0", exp_q.size(), bad_hold);
    end
  endtask

`ifdef SENSOR_PIPE_STATS_EN
  task automatic test_stats();
    int sent = 0, got = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      tick(sent < 5, DW'(sent * 3 + 1), 2'd1, 1'b0, cyc >= 10);
      if (sent < 5 && ir) sent++;
      if (drained) begin
        tests++;
        if (!have || {oc, od} !== e) begin
          fails++; $display("FAIL stats_data got %0d:%h want %0d:%h", oc, od, e[DW+CB-1:DW], e[DW-1:0]);
        end
        got++;
      end
    end
    @(negedge clk);
    tests++;
    if (stall_count !== 16'd7 || sample_count !== 16'd5) begin
      fails++; $display("FAIL stats_count got %0d/%0d want 7/5", stall_count, sample_count);
    end
    tick(1'b1, 16'd9, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    tests++;
    if (stall_count !== 16'hFFFF) begin
      fails++; $display("FAIL stats_sat got %h want ffff", stall_count);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      if (drained) begin
        tests++;
        if (!have || {oc, od} !== e) begin
          fails++; $display("FAIL stats_drain got %0d:%h want %0d:%h", oc, od, e[DW+CB-1:DW], e[DW-1:0]);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (stall_count !== 16'hFFFF || sample_count !== 16'd6) begin
      fails++; $display("FAIL stats_hold got %h/%0d want ffff/6", stall_count, sample_count);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_warmup();
    test_interleave();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef SENSOR_PIPE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
